fd_de_pipe_regs: RTL and testbench

FD_DE_PIPE_REGS -- requirements
Module: fd_de_pipe_regs

---
 rtl/fd_de_pipe_regs_pkg.sv | 47 ++++
 rtl/fwd_mux3.sv | 31 +++
 rtl/fd_de_pipe_regs.sv | 177 +++++++++++++++++
 tb/tb_fd_de_pipe_regs.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_de_pipe_regs_pkg.sv
// Shared definitions for the IF/ID and ID/EX pipeline register slice:
// default widths, the canonical bubble instruction, control-bundle layout
// and forward-select encodings.
package fd_de_pipe_regs_pkg;

    localparam int XLEN_DEF   = 32;
    localparam int INSTR_W    = 32;
    localparam int REG_ADDR_W = 5;

    // addi x0, x0, 0 -- the bubble placed in decode on a flush or reset.
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Control bundle {RegWrite, ResultSrc[1:0], MemWrite, Jump, Branch,
    //                 ALUControl[2:0], ALUSrc}
    localparam int CTRL_W             = 10;
    localparam int CTRL_ALUSRC_BIT    = 0;
    localparam int CTRL_ALUCTRL_LSB   = 1;
    localparam int CTRL_ALUCTRL_W     = 3;
    localparam int CTRL_BRANCH_BIT    = 4;
    localparam int CTRL_JUMP_BIT      = 5;
    localparam int CTRL_MEMWRITE_BIT  = 6;
    localparam int CTRL_RESULTSRC_LSB = 7;
    localparam int CTRL_RESULTSRC_W   = 2;
    localparam int CTRL_REGWRITE_BIT  = 9;

    // Forward-select encodings; FWD_RSVD falls back to the register value.
    typedef enum logic [1:0] {
        FWD_REG  = 2'b00,
        FWD_WB   = 2'b01,
        FWD_MEM  = 2'b10,
        FWD_RSVD = 2'b11
    } fwd_sel_e;

    // Register-address fields of an RV32 instruction word.
    function automatic logic [REG_ADDR_W-1:0] rs1_field(input logic [INSTR_W-1:0] instr);
        return instr[19:15];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rs2_field(input logic [INSTR_W-1:0] instr);
        return instr[24:20];
    endfunction

    function automatic logic [REG_ADDR_W-1:0] rd_field(input logic [INSTR_W-1:0] instr);
        return instr[11:7];
    endfunction

endpackage

// File: rtl/fwd_mux3.sv
// XLEN-wide 3:1 forwarding mux. The reserved select value behaves as the
// register-file path so an unused encoding never produces X.
module fwd_mux3
    import fd_de_pipe_regs_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [1:0]      sel,
    input  logic [XLEN-1:0] d_reg,
    input  logic [XLEN-1:0] d_wb,
    input  logic [XLEN-1:0] d_mem,
    output logic [XLEN-1:0] y
);

    logic [XLEN-1:0] y_s;

    // Select the operand source; anything not WB/MEM takes the register value.
    always_comb begin
        y_s = d_reg;
        case (sel)
            FWD_REG:  y_s = d_reg;
            FWD_WB:   y_s = d_wb;
            FWD_MEM:  y_s = d_mem;
            FWD_RSVD: y_s = d_reg;
            default:  y_s = d_reg;
        endcase
    end

    assign y = y_s;

endmodule

// File: rtl/fd_de_pipe_regs.sv
// IF/ID and ID/EX pipeline registers with stall/flush control, execute-stage
// operand forwarding and saturating stall/flush event counters.
module fd_de_pipe_regs
    import fd_de_pipe_regs_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               StallD,
    input  logic               FlushD,
    input  logic               FlushE,
    input  logic [1:0]         ForwardAE,
    input  logic [1:0]         ForwardBE,
    input  logic [INSTR_W-1:0] InstrF,
    input  logic [XLEN-1:0]    PCF,
    output logic [INSTR_W-1:0] InstrD,
    output logic [XLEN-1:0]    PCD,
    output logic               ValidD,
    output logic [4:0]         Rs1D,
    output logic [4:0]         Rs2D,
    input  logic [CTRL_W-1:0]  CtrlD,
    input  logic [XLEN-1:0]    RD1D,
    input  logic [XLEN-1:0]    RD2D,
    input  logic [XLEN-1:0]    ImmExtD,
    output logic [CTRL_W-1:0]  CtrlE,
    output logic [XLEN-1:0]    PCE,
    output logic [XLEN-1:0]    ImmExtE,
    output logic [4:0]         Rs1E,
    output logic [4:0]         Rs2E,
    output logic [4:0]         RdE,
    output logic               ValidE,
    input  logic [XLEN-1:0]    ALUResultM,
    input  logic [XLEN-1:0]    ResultW,
    output logic [XLEN-1:0]    SrcAE,
    output logic [XLEN-1:0]    WriteDataE,
    output logic [CNT_W-1:0]   StallCnt,
    output logic [CNT_W-1:0]   FlushCnt
);

    // IF/ID state
    logic [INSTR_W-1:0]    instr_d_r;
    logic [XLEN-1:0]       pc_d_r;
    logic                  valid_d_r;

    // ID/EX state
    logic [CTRL_W-1:0]     ctrl_e_r;
    logic [XLEN-1:0]       pc_e_r;
    logic [XLEN-1:0]       imm_e_r;
    logic [XLEN-1:0]       rd1_e_r;
    logic [XLEN-1:0]       rd2_e_r;
    logic [REG_ADDR_W-1:0] rs1_e_r;
    logic [REG_ADDR_W-1:0] rs2_e_r;
    logic [REG_ADDR_W-1:0] rd_e_r;
    logic                  valid_e_r;

    // Event counters
    logic [CNT_W-1:0]      stall_cnt_r;
    logic [CNT_W-1:0]      flush_cnt_r;

    // Decode-stage register addresses, consumed by the hazard unit this cycle.
    logic [REG_ADDR_W-1:0] rs1_d_s;
    logic [REG_ADDR_W-1:0] rs2_d_s;

    assign rs1_d_s = rs1_field(instr_d_r);
    assign rs2_d_s = rs2_field(instr_d_r);

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1);
        end
    endfunction

    // IF/ID register: flush beats stall, stall holds, otherwise load fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr_d_r <= NOP_INSTR;
            pc_d_r    <= '0;
            valid_d_r <= 1'b0;
        end else if (FlushD) begin
            instr_d_r <= NOP_INSTR;
            pc_d_r    <= '0;
            valid_d_r <= 1'b0;
        end else if (!StallD) begin
            instr_d_r <= InstrF;
            pc_d_r    <= PCF;
            valid_d_r <= 1'b1;
        end
    end

    // ID/EX register: a decode stall does not hold it, so a held decode slot
    // is re-issued into execute unless FlushE inserts a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_e_r  <= '0;
            pc_e_r    <= '0;
            imm_e_r   <= '0;
            rd1_e_r   <= '0;
            rd2_e_r   <= '0;
            rs1_e_r   <= '0;
            rs2_e_r   <= '0;
            rd_e_r    <= '0;
            valid_e_r <= 1'b0;
        end else if (FlushE) begin
            ctrl_e_r  <= '0;
            pc_e_r    <= '0;
            imm_e_r   <= '0;
            rd1_e_r   <= '0;
            rd2_e_r   <= '0;
            rs1_e_r   <= '0;
            rs2_e_r   <= '0;
            rd_e_r    <= '0;
            valid_e_r <= 1'b0;
        end else begin
            ctrl_e_r  <= CtrlD;
            pc_e_r    <= pc_d_r;
            imm_e_r   <= ImmExtD;
            rd1_e_r   <= RD1D;
            rd2_e_r   <= RD2D;
            rs1_e_r   <= rs1_d_s;
            rs2_e_r   <= rs2_d_s;
            rd_e_r    <= rd_field(instr_d_r);
            valid_e_r <= valid_d_r;
        end
    end

    // Saturating counters: a stall overridden by a flush is not counted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_r <= '0;
            flush_cnt_r <= '0;
        end else begin
            if (StallD && !FlushD) begin
                stall_cnt_r <= sat_inc(stall_cnt_r);
            end
            if (FlushE) begin
                flush_cnt_r <= sat_inc(flush_cnt_r);
            end
        end
    end

    fwd_mux3 #(.XLEN(XLEN)) u_fwd_a (
        .sel   (ForwardAE),
        .d_reg (rd1_e_r),
        .d_wb  (ResultW),
        .d_mem (ALUResultM),
        .y     (SrcAE)
    );

    fwd_mux3 #(.XLEN(XLEN)) u_fwd_b (
        .sel   (ForwardBE),
        .d_reg (rd2_e_r),
        .d_wb  (ResultW),
        .d_mem (ALUResultM),
        .y     (WriteDataE)
    );

    assign InstrD   = instr_d_r;
    assign PCD      = pc_d_r;
    assign ValidD   = valid_d_r;
    assign Rs1D     = rs1_d_s;
    assign Rs2D     = rs2_d_s;
    assign CtrlE    = ctrl_e_r;
    assign PCE      = pc_e_r;
    assign ImmExtE  = imm_e_r;
    assign Rs1E     = rs1_e_r;
    assign Rs2E     = rs2_e_r;
    assign RdE      = rd_e_r;
    assign ValidE   = valid_e_r;
    assign StallCnt = stall_cnt_r;
    assign FlushCnt = flush_cnt_r;

endmodule

// File: tb/tb_fd_de_pipe_regs.sv
// Self-checking bench for fd_de_pipe_regs: per-cycle reference model feeding
// an expectation queue, a forwarding-select table, and directed corner cases.
module tb_fd_de_pipe_regs;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic             clk = 1'b0;
    logic             reset;
    logic             StallD, FlushD, FlushE;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [31:0]      InstrF;
    logic [XLEN-1:0]  PCF;
    logic [31:0]      InstrD;
    logic [XLEN-1:0]  PCD;
    logic             ValidD;
    logic [4:0]       Rs1D, Rs2D;
    logic [9:0]       CtrlD;
    logic [XLEN-1:0]  RD1D, RD2D, ImmExtD;
    logic [9:0]       CtrlE;
    logic [XLEN-1:0]  PCE, ImmExtE;
    logic [4:0]       Rs1E, Rs2E, RdE;
    logic             ValidE;
    logic [XLEN-1:0]  ALUResultM, ResultW, SrcAE, WriteDataE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fd_de_pipe_regs #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .InstrF(InstrF), .PCF(PCF),
        .InstrD(InstrD), .PCD(PCD), .ValidD(ValidD), .Rs1D(Rs1D), .Rs2D(Rs2D),
        .CtrlD(CtrlD), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD),
        .CtrlE(CtrlE), .PCE(PCE), .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .ValidE(ValidE), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .SrcAE(SrcAE), .WriteDataE(WriteDataE), .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    typedef struct {
        logic [31:0]      instr_d;
        logic [31:0]      pc_d;
        logic             valid_d;
        logic [9:0]       ctrl_e;
        logic [31:0]      pc_e;
        logic [31:0]      imm_e;
        logic [31:0]      rd1_e;
        logic [31:0]      rd2_e;
        logic [4:0]       rs1_e;
        logic [4:0]       rs2_e;
        logic [4:0]       rd_e;
        logic             valid_e;
        logic [CNT_W-1:0] stall_cnt;
        logic [CNT_W-1:0] flush_cnt;
    } exp_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
    } fwd_vec_t;

    exp_t     m;          // reference model state
    exp_t     exp_q[$];   // expectations awaiting the next edge
    fwd_vec_t fwd_tab[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m.instr_d = NOP;  m.pc_d = '0;  m.valid_d = 1'b0;
        m.ctrl_e = '0;    m.pc_e = '0;  m.imm_e = '0;
        m.rd1_e = '0;     m.rd2_e = '0;
        m.rs1_e = '0;     m.rs2_e = '0; m.rd_e = '0;  m.valid_e = 1'b0;
        m.stall_cnt = '0; m.flush_cnt = '0;
    endtask

    task automatic set_idle();
        StallD = 1'b0; FlushD = 1'b0; FlushE = 1'b0;
        ForwardAE = 2'b00; ForwardBE = 2'b00;
        ResultW = 32'h22; ALUResultM = 32'h33;
    endtask

    // Advance the model for one edge with the current inputs, queue the
    // expectation, then clock the DUT and compare against the queue head.
    task automatic step();
        exp_t e;
        exp_t n;
        n = m;
        if (FlushE) begin
            n.ctrl_e = '0; n.pc_e = '0; n.imm_e = '0; n.rd1_e = '0; n.rd2_e = '0;
            n.rs1_e = '0;  n.rs2_e = '0; n.rd_e = '0; n.valid_e = 1'b0;
        end else begin
            n.ctrl_e = CtrlD; n.pc_e = m.pc_d; n.imm_e = ImmExtD;
            n.rd1_e = RD1D;   n.rd2_e = RD2D;
            n.rs1_e = m.instr_d[19:15]; n.rs2_e = m.instr_d[24:20];
            n.rd_e  = m.instr_d[11:7];  n.valid_e = m.valid_d;
        end
        if (FlushD) begin
            n.instr_d = NOP; n.pc_d = '0; n.valid_d = 1'b0;
        end else if (!StallD) begin
            n.instr_d = InstrF; n.pc_d = PCF; n.valid_d = 1'b1;
        end
        if (StallD && !FlushD && m.stall_cnt != 4'hF) n.stall_cnt = m.stall_cnt + 4'd1;
        if (FlushE && m.flush_cnt != 4'hF) n.flush_cnt = m.flush_cnt + 4'd1;
        m = n;
        exp_q.push_back(n);
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("InstrD",   64'(InstrD),   64'(e.instr_d));
        check("PCD",      64'(PCD),      64'(e.pc_d));
        check("ValidD",   64'(ValidD),   64'(e.valid_d));
        check("Rs1D",     64'(Rs1D),     64'(e.instr_d[19:15]));
        check("Rs2D",     64'(Rs2D),     64'(e.instr_d[24:20]));
        check("CtrlE",    64'(CtrlE),    64'(e.ctrl_e));
        check("PCE",      64'(PCE),      64'(e.pc_e));
        check("ImmExtE",  64'(ImmExtE),  64'(e.imm_e));
        check("SrcAE_reg",64'(SrcAE),    64'(e.rd1_e));
        check("WDE_reg",  64'(WriteDataE), 64'(e.rd2_e));
        check("Rs1E",     64'(Rs1E),     64'(e.rs1_e));
        check("Rs2E",     64'(Rs2E),     64'(e.rs2_e));
        check("RdE",      64'(RdE),      64'(e.rd_e));
        check("ValidE",   64'(ValidE),   64'(e.valid_e));
        check("StallCnt", 64'(StallCnt), 64'(e.stall_cnt));
        check("FlushCnt", 64'(FlushCnt), 64'(e.flush_cnt));
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_InstrD"},   64'(InstrD),   64'(NOP));
        check({tag, "_ValidD"},   64'(ValidD),   64'd0);
        check({tag, "_PCD"},      64'(PCD),      64'd0);
        check({tag, "_ValidE"},   64'(ValidE),   64'd0);
        check({tag, "_CtrlE"},    64'(CtrlE),    64'd0);
        check({tag, "_RdE"},      64'(RdE),      64'd0);
        check({tag, "_PCE"},      64'(PCE),      64'd0);
        check({tag, "_StallCnt"}, 64'(StallCnt), 64'd0);
        check({tag, "_FlushCnt"}, 64'(FlushCnt), 64'd0);
    endtask

    // Apply reset across one edge and release it just after the edge.
    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_cleared("reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fwd_tab[0] = '{2'b00, 2'b00, 32'h11, 32'h44};
        fwd_tab[1] = '{2'b01, 2'b01, 32'h22, 32'h22};
        fwd_tab[2] = '{2'b10, 2'b10, 32'h33, 32'h33};
        fwd_tab[3] = '{2'b11, 2'b11, 32'h11, 32'h44};
        fwd_tab[4] = '{2'b01, 2'b10, 32'h22, 32'h33};
        fwd_tab[5] = '{2'b10, 2'b11, 32'h33, 32'h44};

        set_idle();
        InstrF = 32'h0; PCF = '0; CtrlD = '0; RD1D = '0; RD2D = '0; ImmExtD = '0;
        do_reset();

        // Single instruction flows through both registers.
        InstrF = 32'h0050_0093; PCF = 32'h10; CtrlD = 10'h2A1;
        RD1D = 32'hA; RD2D = 32'hB; ImmExtD = 32'h5;
        step();
        check("basic_InstrD", 64'(InstrD), 64'h0050_0093);
        check("basic_Rs1D",   64'(Rs1D),   64'd0);
        check("basic_ValidD", 64'(ValidD), 64'd1);
        InstrF = 32'h0020_8113; PCF = 32'h14;
        step();
        check("basic_RdE",    64'(RdE),    64'd1);
        check("basic_ValidE", 64'(ValidE), 64'd1);
        check("basic_PCE",    64'(PCE),    64'h10);

        // Stall decode while flushing execute.
        StallD = 1'b1; FlushE = 1'b1; InstrF = 32'h0030_0193; PCF = 32'h18;
        step();
        check("stflE_InstrD",   64'(InstrD),   64'h0020_8113);
        check("stflE_ValidE",   64'(ValidE),   64'd0);
        check("stflE_CtrlE",    64'(CtrlE),    64'd0);
        check("stflE_StallCnt", 64'(StallCnt), 64'd1);
        check("stflE_FlushCnt", 64'(FlushCnt), 64'd1);

        // Flush decode wins over a simultaneous stall and is not counted.
        StallD = 1'b1; FlushD = 1'b1; FlushE = 1'b0;
        step();
        check("stflD_InstrD",   64'(InstrD),   64'(NOP));
        check("stflD_ValidD",   64'(ValidD),   64'd0);
        check("stflD_StallCnt", 64'(StallCnt), 64'd1);

        // Load RD1E=0x11 / RD2E=0x44 then sweep the forward selects.
        set_idle();
        RD1D = 32'h11; RD2D = 32'h44;
        step();
        for (int i = 0; i < 6; i++) begin
            ForwardAE = fwd_tab[i].fa;
            ForwardBE = fwd_tab[i].fb;
            #1;
            check($sformatf("fwdA_%0d", i), 64'(SrcAE),      64'(fwd_tab[i].exp_a));
            check($sformatf("fwdB_%0d", i), 64'(WriteDataE), 64'(fwd_tab[i].exp_b));
        end
        ForwardAE = 2'b00; ForwardBE = 2'b00;

        // Randomised stream against the reference model.
        for (int i = 0; i < 40; i++) begin
            StallD  = ($urandom_range(0, 3) == 0);
            FlushD  = ($urandom_range(0, 5) == 0);
            FlushE  = ($urandom_range(0, 4) == 0);
            InstrF  = $urandom;
            PCF     = $urandom;
            CtrlD   = 10'($urandom);
            RD1D    = $urandom;
            RD2D    = $urandom;
            ImmExtD = $urandom;
            step();
        end

        // Stall counter saturates at all-ones.
        set_idle();
        do_reset();
        StallD = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("sat_StallCnt", 64'(StallCnt), 64'hF);
        check("sat_FlushCnt", 64'(FlushCnt), 64'h0);

        // Asynchronous reset between edges clears everything immediately.
        set_idle();
        FlushE = 1'b1; InstrF = 32'h00A0_0513; PCF = 32'h40;
        step();
        FlushE = 1'b0;
        step();
        StallD = 1'b1; FlushE = 1'b1;
        #3;
        reset = 1'b1;
        #1;
        check_cleared("async");
        @(posedge clk);
        #1;
        check_cleared("held");
        reset = 1'b0;
        model_reset();
        set_idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
